// File: rtl/l2_cache_control.sv
// Direct-mapped, write-back, write-allocate L2 controller with tag/valid/dirty state and line store.
// Optional hit/miss performance counters are enabled by defining L2_PERF_CNT_EN.
//
// state  | meaning
// IDLE   | waiting for an L1 request; issues the array read when one arrives
// LOOKUP | registered tag/data available; resolves hit or miss
// WBACK  | writing the dirty victim line back to physical memory
// FETCH  | reading the requested line from physical memory
// FILL   | write miss: whole line overwritten from mem_wdata, no fetch needed
module l2_cache_control #(
  parameter int s_index  = 3,
  parameter int s_offset = 5,
  parameter int s_addr   = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [31:0]   mem_address,
  input  logic [255:0]  mem_wdata,
  output logic [255:0]  mem_rdata,
  output logic          mem_resp,
  output logic          pmem_read,
  output logic          pmem_write,
  output logic [31:0]   pmem_address,
  output logic [255:0]  pmem_wdata,
  input  logic [255:0]  pmem_rdata,
  input  logic          pmem_resp,
  output logic [31:0]   hit_count,
  output logic [31:0]   miss_count
);

  localparam int s_tag   = s_addr - s_index - s_offset;
  localparam int n_lines = 2 ** s_index;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_WBACK,
    ST_FETCH,
    ST_FILL
  } state_t;

  state_t state_q, state_d;
  logic   refetch_q, refetch_d;
  logic [n_lines-1:0] valid_q, valid_d;
  logic [n_lines-1:0] dirty_q, dirty_d;

  logic [255:0]     data_arr [n_lines];
  logic [s_tag-1:0] tag_arr  [n_lines];
  logic [255:0]     data_rd_q;
  logic [s_tag-1:0] tag_rd_q;

  logic [s_index-1:0] idx;
  logic [s_tag-1:0]   req_tag;
  logic               is_wr;
  logic               hit;
  logic               arr_rd;
  logic               arr_we;
  logic [255:0]       arr_wdata;
  logic               hit_inc;
  logic               miss_inc;

  assign idx     = mem_address[s_offset +: s_index];
  assign req_tag = mem_address[s_addr-1 -: s_tag];
  assign is_wr   = mem_write;
  assign hit     = valid_q[idx] && (tag_rd_q == req_tag);

  always_comb begin
    state_d      = state_q;
    refetch_d    = refetch_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    arr_rd       = 1'b0;
    arr_we       = 1'b0;
    arr_wdata    = '0;
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    hit_inc      = 1'b0;
    miss_inc     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        refetch_d = 1'b0;
        if (mem_read || mem_write) begin
          arr_rd  = 1'b1;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (hit) begin
          hit_inc  = !refetch_q;
          mem_resp = 1'b1;
          state_d  = ST_IDLE;
          if (is_wr) begin
            arr_we       = 1'b1;
            arr_wdata    = mem_wdata;
            dirty_d[idx] = 1'b1;
          end else begin
            mem_rdata = data_rd_q;
          end
        end else begin
          // the lookup that follows a fetch always hits, so this only counts real misses
          miss_inc = !refetch_q;
          if (valid_q[idx] && dirty_q[idx]) state_d = ST_WBACK;
          else if (is_wr)                   state_d = ST_FILL;
          else                              state_d = ST_FETCH;
        end
      end
      ST_WBACK: begin
        // no array read is issued here, so the registered victim line stays put
        pmem_write   = 1'b1;
        pmem_address = {tag_rd_q, idx, {s_offset{1'b0}}};
        pmem_wdata   = data_rd_q;
        if (pmem_resp) begin
          dirty_d[idx] = 1'b0;
          state_d      = is_wr ? ST_FILL : ST_FETCH;
        end
      end
      ST_FETCH: begin
        pmem_read    = 1'b1;
        pmem_address = {req_tag, idx, {s_offset{1'b0}}};
        if (pmem_resp) begin
          arr_we       = 1'b1;
          arr_wdata    = pmem_rdata;
          valid_d[idx] = 1'b1;
          dirty_d[idx] = 1'b0;
          arr_rd       = 1'b1;
          refetch_d    = 1'b1;
          state_d      = ST_LOOKUP;
        end
      end
      ST_FILL: begin
        arr_we       = 1'b1;
        arr_wdata    = mem_wdata;
        valid_d[idx] = 1'b1;
        dirty_d[idx] = 1'b1;
        mem_resp     = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      refetch_q <= 1'b0;
      valid_q   <= '0;
      dirty_q   <= '0;
    end else begin
      state_q   <= state_d;
      refetch_q <= refetch_d;
      valid_q   <= valid_d;
      dirty_q   <= dirty_d;
    end
  end

  // line store: contents need no reset; a read in the same cycle as a write returns the new line
  always_ff @(posedge clk) begin
    if (arr_we) begin
      data_arr[idx] <= arr_wdata;
      tag_arr[idx]  <= req_tag;
    end
    if (arr_rd) begin
      data_rd_q <= arr_we ? arr_wdata : data_arr[idx];
      tag_rd_q  <= arr_we ? req_tag : tag_arr[idx];
    end
  end

`ifdef L2_PERF_CNT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q + 32'(hit_inc);
    miss_cnt_d = miss_cnt_q + 32'(miss_inc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  logic unused_perf;
  assign unused_perf = hit_inc ^ miss_inc;
  assign hit_count   = '0;
  assign miss_count  = '0;
`endif

  logic unused_offset;
  assign unused_offset = ^mem_address[s_offset-1:0];

endmodule
